// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment display driver.
// Scans NUM_DIGITS hex digits, one per REFRESH_DIV-cycle slot, with a blank
// guard at the start of each slot, PWM brightness, decimal points,
// leading-zero blanking and a frame-coherent snapshot of the inputs.
// Ports:
//   clk, reset   clock; synchronous active-low reset
//   en           1 = display on, 0 = all anodes off
//   in           hex digits, digit k = in[4k+3:4k], digit 0 rightmost
//   dp_in        decimal point per digit, 1 = lit
//   blank_lz     1 = suppress leading zeros
//   brightness   PWM duty select (all-ones = 100%)
//   digit        segments gfedcba, active-low
//   dp           decimal point, active-low
//   an           anodes, active-low, at most one low
//   frame_tick   one-cycle pulse following a snapshot capture
module sevenseg_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 10000,
  parameter int unsigned GUARD       = 2,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              digit,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [BRIGHT_W-1:0]     pwm_cnt;
  logic                    prime;
  logic [4*NUM_DIGITS-1:0] snap_val;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic                    snap_lz;

  logic                    slot_end_c;
  logic                    frame_end_c;
  logic                    capture_c;
  logic                    guard_ok_c;
  logic                    lit_c;
  logic [NUM_DIGITS-1:0]   blank_c;
  logic                    above_zero_c;
  logic [3:0]              cur_nib_c;
  logic                    cur_dp_c;
  logic                    cur_blank_c;
  logic [NUM_DIGITS-1:0]   an_nxt_c;
  logic [6:0]              digit_nxt_c;
  logic                    dp_nxt_c;

  // Active-low hex decode, segment order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot / frame boundaries; a frame ends when the last digit's slot ends.
  assign slot_end_c  = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end_c = slot_end_c && (idx == IDX_W'(NUM_DIGITS - 1));
  assign capture_c   = prime || frame_end_c;

  // Guard window; a zero guard is resolved at elaboration.
  if (GUARD == 0) begin : g_no_guard
    assign guard_ok_c = 1'b1;
  end else begin : g_guard
    assign guard_ok_c = (cnt >= CNT_W'(GUARD));
  end

  assign lit_c = en && guard_ok_c && (pwm_cnt <= brightness);

  // Leading-zero mask: scan from the top digit down while everything seen is zero.
  always_comb begin
    blank_c      = '0;
    above_zero_c = snap_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      above_zero_c = above_zero_c && (snap_val[4*k +: 4] == 4'h0);
      blank_c[k]   = above_zero_c;
    end
  end

  // Select the snapshot fields for the digit currently being scanned.
  always_comb begin
    cur_nib_c   = 4'h0;
    cur_dp_c    = 1'b0;
    cur_blank_c = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib_c   = snap_val[4*k +: 4];
        cur_dp_c    = snap_dp[k];
        cur_blank_c = blank_c[k];
      end
    end
  end

  // Next registered display values; everything dark when no anode is driven.
  always_comb begin
    an_nxt_c    = '1;
    digit_nxt_c = 7'h7F;
    dp_nxt_c    = 1'b1;
    if (lit_c) begin
      an_nxt_c    = ~(NUM_DIGITS'(1) << idx);
      digit_nxt_c = cur_blank_c ? 7'h7F : hex_to_seg(cur_nib_c);
      dp_nxt_c    = ~cur_dp_c;
    end
  end

  // Counters, snapshot and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= '0;
      pwm_cnt    <= '0;
      prime      <= 1'b1;
      snap_val   <= '0;
      snap_dp    <= '0;
      snap_lz    <= 1'b0;
      an         <= '1;
      digit      <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt     <= slot_end_c ? '0 : cnt + CNT_W'(1);
      pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
      if (slot_end_c) begin
        idx <= frame_end_c ? '0 : idx + IDX_W'(1);
      end
      prime      <= 1'b0;
      frame_tick <= capture_c;
      if (capture_c) begin
        snap_val <= in;
        snap_dp  <= dp_in;
        snap_lz  <= blank_lz;
      end
      an    <= an_nxt_c;
      digit <= digit_nxt_c;
      dp    <= dp_nxt_c;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Testbench for sevenseg_scan: three instances share one clock.
//   u0 (4 digits, DIV=8, GUARD=1): frame scoreboard of digit presentations.
//   u1 (4 digits, DIV=64, GUARD=0): PWM duty counts per 16-cycle window.
//   u2 (4 digits, DIV=8, GUARD=1): enable gap, decimal point, mid-slot reset.
module tb_sevenseg_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- u0 ----------------
  logic        r0, en0, lz0;
  logic [15:0] in0;
  logic [3:0]  dpin0, b0;
  logic [6:0]  dig0;
  logic        dp0, tk0;
  logic [3:0]  an0;

  sevenseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(1), .BRIGHT_W(4)) u0 (
    .clk(clk), .reset(r0), .en(en0), .in(in0), .dp_in(dpin0), .blank_lz(lz0),
    .brightness(b0), .digit(dig0), .dp(dp0), .an(an0), .frame_tick(tk0));

  // ---------------- u1 ----------------
  logic        r1;
  logic [3:0]  b1;
  logic [6:0]  dig1;
  logic        dp1, tk1;
  logic [3:0]  an1;

  sevenseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(64), .GUARD(0), .BRIGHT_W(4)) u1 (
    .clk(clk), .reset(r1), .en(1'b1), .in(16'h1234), .dp_in(4'b0000), .blank_lz(1'b0),
    .brightness(b1), .digit(dig1), .dp(dp1), .an(an1), .frame_tick(tk1));

  // ---------------- u2 ----------------
  logic        r2, en2;
  logic [15:0] in2;
  logic [3:0]  dpin2;
  logic [6:0]  dig2;
  logic        dp2, tk2;
  logic [3:0]  an2;

  sevenseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(8), .GUARD(1), .BRIGHT_W(4)) u2 (
    .clk(clk), .reset(r2), .en(en2), .in(in2), .dp_in(dpin2), .blank_lz(1'b0),
    .brightness(4'hF), .digit(dig2), .dp(dp2), .an(an2), .frame_tick(tk2));

  // ---------------- u0 scoreboard ----------------
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] cur_an  = 4'hF;
  int         lit_cnt = 0;
  bit         stop_req = 1'b0;
  bit         stopped  = 1'b0;

  // Monitor: one expected entry per digit presentation (maximal run of one lit anode).
  always @(negedge clk) begin
    exp_t e;
    if (!stopped) begin
      chk("an_onehot", 32'($countones(~an0) <= 1), 32'd1);
      if (an0 == 4'hF) begin
        chk("dark_digit", 32'(dig0), 32'h7F);
        chk("dark_dp", 32'(dp0), 32'd1);
      end
      if (an0 == cur_an && cur_an != 4'hF) begin
        lit_cnt++;
      end else begin
        if (cur_an != 4'hF) chk("lit_len", 32'(lit_cnt), 32'd7);
        cur_an = 4'hF;
        if (an0 != 4'hF) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: an %b digit %h with no expected entry", an0, dig0);
          end else begin
            e = sb.pop_front();
            chk("pres_an", 32'(an0), 32'(e.an));
            chk("pres_digit", 32'(dig0), 32'(e.seg));
            chk("pres_dp", 32'(dp0), 32'(e.dp));
          end
          cur_an  = an0;
          lit_cnt = 1;
        end
        if (stop_req && sb.size() == 0 && cur_an == 4'hF) stopped = 1'b1;
      end
    end
  end

  // Apply inputs (after dly cycles), wait for the capture tick, push that frame's expectations.
  task automatic do_frame(input logic [15:0] v, input logic [3:0] d, input logic lz,
                          input int dly, input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s [4];
    bit got;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    repeat (dly) @(negedge clk);
    in0 = v; dpin0 = d; lz0 = lz;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (tk0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout: no tick for in=%h", v);
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_t e;
        e.an  = ~(4'b0001 << k);
        e.seg = s[k];
        e.dp  = ~d[k];
        sb.push_back(e);
      end
    end
  endtask

  task automatic t0();
    r0 = 1'b0; en0 = 1'b1; b0 = 4'hF; in0 = 16'h1234; dpin0 = 4'b0000; lz0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("u0_rst_an", 32'(an0), 32'hF);
    chk("u0_rst_digit", 32'(dig0), 32'h7F);
    chk("u0_rst_dp", 32'(dp0), 32'd1);
    chk("u0_rst_tick", 32'(tk0), 32'd0);
    r0 = 1'b1;
    do_frame(16'h1234, 4'b0000, 1'b0, 0,  7'h19, 7'h30, 7'h24, 7'h79);
    do_frame(16'h0050, 4'b0000, 1'b1, 0,  7'h40, 7'h12, 7'h7F, 7'h7F);
    do_frame(16'h0000, 4'b0100, 1'b1, 0,  7'h40, 7'h7F, 7'h7F, 7'h7F);
    do_frame(16'h0305, 4'b0000, 1'b1, 0,  7'h12, 7'h40, 7'h30, 7'h7F);
    do_frame(16'h1234, 4'b0000, 1'b0, 0,  7'h19, 7'h30, 7'h24, 7'h79);
    // Change arrives 10 cycles into the 1234 frame; it must wait for the next capture.
    do_frame(16'hABCD, 4'b0000, 1'b0, 10, 7'h21, 7'h46, 7'h03, 7'h08);
    stop_req = 1'b1;
    for (int i = 0; i < 200 && !stopped; i++) @(negedge clk);
    if (!stopped) begin
      checks++;
      errors++;
      $display("FAIL sb_drain_timeout: %0d entries left", sb.size());
    end
  endtask

  // PWM: slot s has anode ~(1<<s); per-16-cycle lit counts for brightness 3, 0, F.
  task automatic t1();
    int win_lit, other;
    logic [3:0] exp_an;
    int exp_cnt;
    r1 = 1'b0; b1 = 4'h3;
    repeat (3) @(negedge clk);
    chk("u1_rst_an", 32'(an1), 32'hF);
    r1 = 1'b1;
    win_lit = 0; other = 0;
    for (int n = 0; n < 192; n++) begin
      @(negedge clk);
      exp_an  = (n < 64) ? 4'b1110 : (n < 128) ? 4'b1101 : 4'b1011;
      exp_cnt = (n < 64) ? 4 : (n < 128) ? 1 : 16;
      if (an1 == exp_an) win_lit++;
      else if (an1 != 4'hF) other++;
      if (n % 16 == 15) begin
        chk("u1_window_lit", 32'(win_lit), 32'(exp_cnt));
        win_lit = 0;
      end
      if (n == 63)  b1 = 4'h0;
      if (n == 127) b1 = 4'hF;
    end
    chk("u1_wrong_anode", 32'(other), 32'd0);
  endtask

  // Enable gap, decimal point and mid-slot reset; n counts negedges after reset release.
  task automatic t2();
    int ticks;
    r2 = 1'b0; en2 = 1'b1; in2 = 16'h1234; dpin2 = 4'b0100;
    repeat (3) @(negedge clk);
    r2 = 1'b1;
    ticks = 0;
    for (int n = 0; n <= 76; n++) begin
      @(negedge clk);
      if (tk2) ticks++;
      case (n)
        0:  chk("u2_tick_first", 32'(tk2), 32'd1);
        1:  chk("u2_tick_once", 32'(tk2), 32'd0);
        5:  begin chk("u2_an_d0", 32'(an2), 32'hE); chk("u2_dig_d0", 32'(dig2), 32'h19); end
        10: en2 = 1'b0;
        11: begin chk("u2_en_off_an", 32'(an2), 32'hF); chk("u2_en_off_dig", 32'(dig2), 32'h7F); end
        17: chk("u2_en_off_an2", 32'(an2), 32'hF);
        30: begin chk("u2_en_off_an3", 32'(an2), 32'hF); en2 = 1'b1; end
        31: begin
              chk("u2_resume_an", 32'(an2), 32'h7);
              chk("u2_resume_dig", 32'(dig2), 32'h79);
              chk("u2_tick_frame", 32'(tk2), 32'd1);
            end
        33: begin chk("u2_wrap_an", 32'(an2), 32'hE); chk("u2_wrap_dig", 32'(dig2), 32'h19); end
        42: begin chk("u2_d1_an", 32'(an2), 32'hD); chk("u2_d1_dp", 32'(dp2), 32'd1); end
        50: begin
              chk("u2_d2_an", 32'(an2), 32'hB);
              chk("u2_d2_dig", 32'(dig2), 32'h24);
              chk("u2_d2_dp", 32'(dp2), 32'd0);
            end
        52: begin r2 = 1'b0; in2 = 16'h5678; end
        53: begin
              chk("u2_midrst_an", 32'(an2), 32'hF);
              chk("u2_midrst_dig", 32'(dig2), 32'h7F);
              chk("u2_midrst_dp", 32'(dp2), 32'd1);
              chk("u2_midrst_tick", 32'(tk2), 32'd0);
            end
        55: r2 = 1'b1;
        56: chk("u2_rel_tick", 32'(tk2), 32'd1);
        57: begin chk("u2_rel_an", 32'(an2), 32'hE); chk("u2_rel_dig", 32'(dig2), 32'h00); end
        65: begin chk("u2_rel_an1", 32'(an2), 32'hD); chk("u2_rel_dig1", 32'(dig2), 32'h78); end
        73: begin
              chk("u2_rel_an2", 32'(an2), 32'hB);
              chk("u2_rel_dig2", 32'(dig2), 32'h02);
              chk("u2_rel_dp2", 32'(dp2), 32'd0);
            end
        default: ;
      endcase
    end
    chk("u2_tick_count", 32'(ticks), 32'd3);
  endtask

  initial begin
    fork
      t0();
      t1();
      t2();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
